// File: rtl/pll_drp_reconfig.sv
// Buffered DRP read-modify-write sequencer for PLL reconfiguration.
// Holds the PLL in reset, applies queued masked writes, then waits for relock.
module pll_drp_reconfig #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned DRDY_TIMEOUT = 255,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [6:0]               wr_addr,
  input  logic [15:0]              wr_mask,
  input  logic [15:0]              wr_data,
  input  logic                     start,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     drp_den,
  output logic                     drp_dwe,
  output logic [6:0]               drp_daddr,
  output logic [15:0]              drp_di,
  input  logic [15:0]              drp_do,
  input  logic                     drp_drdy,
  output logic                     pll_rst,
  input  logic                     pll_locked
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned TMAX = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE, HOLD, RD, RD_WAIT, WR, WR_WAIT, RELEASE, LOCK_WAIT
  } state_t;

  state_t          state, state_n;
  logic            lock_meta, locked_s;
  logic [TW-1:0]   tmo_cnt, tmo_n;
  logic [AW-1:0]   wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [CW-1:0]   count_n;
  logic            error_n, done_n;
  logic [6:0]      daddr_n;
  logic [15:0]     di_n;
  logic            wr_accept, drdy_tmo, lock_tmo;

  logic [6:0]      fifo_addr [DEPTH];
  logic [15:0]     fifo_mask [DEPTH];
  logic [15:0]     fifo_data [DEPTH];

  // Entry storage; pointers and count carry the valid range.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_mask[wr_ptr] <= wr_mask;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_n   = state;
    wr_ptr_n  = wr_ptr;
    rd_ptr_n  = rd_ptr;
    count_n   = count;
    error_n   = error;
    daddr_n   = drp_daddr;
    di_n      = drp_di;
    wr_accept = (state == IDLE) && wr_en && !full;
    drdy_tmo  = (tmo_cnt == TW'(DRDY_TIMEOUT - 1));
    lock_tmo  = (tmo_cnt == TW'(LOCK_TIMEOUT - 1));

    if (wr_accept) begin
      wr_ptr_n = wr_ptr + AW'(1);
      count_n  = count + CW'(1);
    end

    case (state)
      IDLE: begin
        if (start && (count_n != '0)) begin
          error_n = 1'b0;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_n = RD;
        end else if (lock_tmo) begin
          error_n = 1'b1;
          state_n = IDLE;
        end
      end
      RD: state_n = RD_WAIT;
      RD_WAIT: begin
        if (drp_drdy) begin
          di_n    = (drp_do & fifo_mask[rd_ptr]) | (fifo_data[rd_ptr] & ~fifo_mask[rd_ptr]);
          state_n = WR;
        end else if (drdy_tmo) begin
          error_n  = 1'b1;
          count_n  = '0;
          rd_ptr_n = wr_ptr;
          state_n  = IDLE;
        end
      end
      WR: state_n = WR_WAIT;
      WR_WAIT: begin
        if (drp_drdy) begin
          rd_ptr_n = rd_ptr + AW'(1);
          count_n  = count - CW'(1);
          state_n  = (count == CW'(1)) ? RELEASE : RD;
        end else if (drdy_tmo) begin
          error_n  = 1'b1;
          count_n  = '0;
          rd_ptr_n = wr_ptr;
          state_n  = IDLE;
        end
      end
      RELEASE: state_n = LOCK_WAIT;
      LOCK_WAIT: begin
        if (locked_s) begin
          state_n = IDLE;
        end else if (lock_tmo) begin
          error_n = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (state_n == RD) daddr_n = fifo_addr[rd_ptr_n];

    if (state_n != state) begin
      tmo_n = '0;
    end else if (state inside {HOLD, RD_WAIT, WR_WAIT, LOCK_WAIT}) begin
      tmo_n = tmo_cnt + TW'(1);
    end else begin
      tmo_n = tmo_cnt;
    end

    done_n = (state != IDLE) && (state_n == IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
      tmo_cnt   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      drp_den   <= 1'b0;
      drp_dwe   <= 1'b0;
      drp_daddr <= '0;
      drp_di    <= '0;
      pll_rst   <= 1'b0;
    end else begin
      state     <= state_n;
      lock_meta <= pll_locked;
      locked_s  <= lock_meta;
      tmo_cnt   <= tmo_n;
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      full      <= (count_n == CW'(DEPTH));
      busy      <= (state_n != IDLE);
      done      <= done_n;
      error     <= error_n;
      drp_den   <= (state_n == RD) || (state_n == WR);
      drp_dwe   <= (state_n == WR);
      drp_daddr <= daddr_n;
      drp_di    <= di_n;
      pll_rst   <= state_n inside {HOLD, RD, RD_WAIT, WR, WR_WAIT, RELEASE};
    end
  end

endmodule

// File: tb/tb_pll_drp_reconfig.sv
// Directed bench for pll_drp_reconfig with a small DRP port and PLL lock model.
module tb_pll_drp_reconfig;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [6:0]  wr_addr = '0;
  logic [15:0] wr_mask = '0;
  logic [15:0] wr_data = '0;
  logic        start = 1'b0;
  logic [3:0]  count;
  logic        full, busy, done, error;
  logic        drp_den, drp_dwe;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic [15:0] drp_do = '0;
  logic        drp_drdy = 1'b0;
  logic        pll_rst;
  logic        pll_locked = 1'b0;

  logic        drdy_stall = 1'b0;
  logic        lock_stuck = 1'b0;
  int          pend = 0;
  logic        pend_we = 1'b0;
  logic [6:0]  pend_addr = '0;
  int          lk_cnt = 0;

  int          tr_n = 0;
  logic        tr_we   [64];
  logic [6:0]  tr_addr [64];
  logic [15:0] tr_di   [64];
  logic        tr_prst [64];
  int          done_cnt = 0;

  int          n_chk = 0;
  int          n_pass = 0;

  pll_drp_reconfig dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask),
    .wr_data(wr_data), .start(start), .count(count), .full(full), .busy(busy),
    .done(done), .error(error), .drp_den(drp_den), .drp_dwe(drp_dwe),
    .drp_daddr(drp_daddr), .drp_di(drp_di), .drp_do(drp_do), .drp_drdy(drp_drdy),
    .pll_rst(pll_rst), .pll_locked(pll_locked)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rd_val(input logic [6:0] a);
    return (a == 7'h08) ? 16'hFFFF : ({9'h0, a} ^ 16'hA5A5);
  endfunction

  // DRP slave: records each strobe, answers two cycles later unless stalled.
  always @(posedge clk) begin
    drp_drdy <= 1'b0;
    if (drp_den) begin
      if (tr_n < 64) begin
        tr_we[tr_n]   <= drp_dwe;
        tr_addr[tr_n] <= drp_daddr;
        tr_di[tr_n]   <= drp_di;
        tr_prst[tr_n] <= pll_rst;
        tr_n          <= tr_n + 1;
      end
      pend      <= 2;
      pend_we   <= drp_dwe;
      pend_addr <= drp_daddr;
    end else if (pend != 0) begin
      if (pend == 1 && !drdy_stall) begin
        drp_drdy <= 1'b1;
        drp_do   <= pend_we ? 16'h0000 : rd_val(pend_addr);
      end
      pend <= pend - 1;
    end
  end

  // PLL: lock drops under reset and returns a few cycles after release.
  always @(posedge clk) begin
    if (rst || pll_rst) begin
      lk_cnt     <= 0;
      pll_locked <= 1'b0;
    end else if (lk_cnt < 4) begin
      lk_cnt <= lk_cnt + 1;
    end else begin
      pll_locked <= !lock_stuck;
    end
  end

  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                      input logic with_start);
    wr_en = 1'b1; wr_addr = a; wr_mask = m; wr_data = d; start = with_start;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
    end
    if (!seen) check({tag, " done seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_write(input string tag, input int budget);
    bit seen;
    int cyc;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (drp_den && drp_dwe) seen = 1'b1;
    end
    if (!seen) check({tag, " write seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    int cyc, base, snap;
    bit seen;

    repeat (3) @(negedge clk);
    check("reset flags", {21'h0, count, full, busy, done, error, drp_den, drp_dwe, pll_rst}, 32'h0);
    check("reset drp bus", {9'h0, drp_daddr, drp_di}, 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Single masked entry: 0xFFFF & 0x1000 | 0x0145 & 0xEFFF = 0x1145
    push(7'h08, 16'h1000, 16'h0145, 1'b0);
    check("t1 count", 32'(count), 32'd1);
    base = tr_n;
    snap = done_cnt;
    pulse_start();
    check("t1 hold", {30'h0, pll_rst, busy}, 32'h3);
    wait_done("t1", 300, cyc);
    repeat (3) @(negedge clk);
    check("t1 ntr", 32'(tr_n - base), 32'd2);
    check("t1 rd", {23'h0, tr_we[base], tr_addr[base], tr_prst[base]}, {23'h0, 1'b0, 7'h08, 1'b1});
    check("t1 wr", {7'h0, tr_we[base+1], tr_addr[base+1], tr_prst[base+1], tr_di[base+1]},
          {7'h0, 1'b1, 7'h08, 1'b1, 16'h1145});
    check("t1 done pulses", 32'(done_cnt - snap), 32'd1);
    check("t1 end", {28'h0, error, busy, pll_rst, 1'b0}, 32'h0);

    // Full buffer: 8 entries accepted, 9th dropped, applied in order
    for (int i = 0; i < 8; i++) push(7'(8'h10 + i), 16'h0000, 16'(16'h1000 + i * 16'h0111), 1'b0);
    check("t2 full", {27'h0, count, full}, {27'h0, 4'd8, 1'b1});
    push(7'h7F, 16'h0000, 16'hDEAD, 1'b0);
    check("t2 9th dropped", 32'(count), 32'd8);
    base = tr_n;
    pulse_start();
    wait_done("t2", 1000, cyc);
    repeat (2) @(negedge clk);
    check("t2 ntr", 32'(tr_n - base), 32'd16);
    for (int i = 0; i < 8; i++) begin
      check("t2 rd", {24'h0, tr_we[base+2*i], tr_addr[base+2*i]}, {24'h0, 1'b0, 7'(8'h10 + i)});
      check("t2 wr", {8'h0, tr_we[base+2*i+1], tr_addr[base+2*i+1], tr_di[base+2*i+1]},
            {8'h0, 1'b1, 7'(8'h10 + i), 16'(16'h1000 + i * 16'h0111)});
    end
    check("t2 count", {27'h0, count, full}, 32'h0);

    // Start with empty buffer is ignored
    base = tr_n;
    pulse_start();
    check("t3 empty busy", 32'(busy), 32'd0);
    repeat (6) @(negedge clk);
    check("t3 empty no drp", 32'(tr_n - base), 32'd0);

    // wr_en + start together applies the entry; wr_en while busy is dropped
    // 0xA587 & 0x00FF | 0xAB00 & 0xFF00 = 0xAB87
    push(7'h22, 16'h00FF, 16'hAB00, 1'b1);
    check("t3 busy", 32'(busy), 32'd1);
    push(7'h33, 16'h0000, 16'h1234, 1'b0);
    check("t3 busy drop", 32'(count), 32'd1);
    wait_done("t3", 300, cyc);
    repeat (2) @(negedge clk);
    check("t3 ntr", 32'(tr_n - base), 32'd2);
    check("t3 wr", {8'h0, tr_we[base+1], tr_addr[base+1], tr_di[base+1]}, {8'h0, 1'b1, 7'h22, 16'hAB87});
    check("t3 count", 32'(count), 32'd0);

    // DRDY timeout: strobe at n=0, 255 wait cycles, done at n=256
    push(7'h40, 16'h0, 16'h1, 1'b0);
    push(7'h41, 16'h0, 16'h2, 1'b0);
    drdy_stall = 1'b1;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (drp_den) seen = 1'b1;
      else @(negedge clk);
    end
    check("t4 read seen", 32'(seen), 32'd1);
    wait_done("t4", 400, cyc);
    check("t4 latency", 32'(cyc), 32'd256);
    check("t4 state", {26'h0, count, error, pll_rst}, {26'h0, 4'd0, 1'b1, 1'b0});
    drdy_stall = 1'b0;
    repeat (10) @(negedge clk);
    check("t4 error sticky", 32'(error), 32'd1);

    // Lock timeout: 65535 cycles in LOCK_WAIT after pll_rst falls
    lock_stuck = 1'b1;
    push(7'h50, 16'h0, 16'h5, 1'b0);
    pulse_start();
    check("t5 start clears error", 32'(error), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (!pll_rst) seen = 1'b1;
    end
    check("t5 release seen", 32'(seen), 32'd1);
    wait_done("t5", 70000, cyc);
    check("t5 latency", 32'(cyc), 32'd65535);
    check("t5 error", {30'h0, error, pll_rst}, 32'h2);
    lock_stuck = 1'b0;
    repeat (10) @(negedge clk);
    push(7'h51, 16'h0, 16'h6, 1'b0);
    pulse_start();
    check("t5 restart clears", 32'(error), 32'd0);
    wait_done("t5b", 300, cyc);
    check("t5b clean", {30'h0, error, busy}, 32'h0);

    // Reset while in WR_WAIT
    repeat (4) @(negedge clk);
    push(7'h60, 16'h0, 16'h7, 1'b0);
    push(7'h61, 16'h0, 16'h8, 1'b0);
    pulse_start();
    wait_write("t6", 100);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6 flags", {21'h0, count, full, busy, done, error, drp_den, drp_dwe, pll_rst}, 32'h0);
    check("t6 drp bus", {9'h0, drp_daddr, drp_di}, 32'h0);
    rst = 1'b0;
    base = tr_n;
    repeat (20) @(negedge clk);
    check("t6 no strobes", 32'(tr_n - base), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pll_drp_reconfig.md
PLL_DRP_RECONFIG -- requirements
Module: pll_drp_reconfig

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning write-buffer entries (power of 2, 2..16).
REQ-002 SHALL have parameter DRDY_TIMEOUT, default 255, meaning max cycles waiting for drp_drdy.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65535, meaning max cycles waiting for lock change.
REQ-004 SHALL have ports, one per line:
- clk  in  1  sole clock; DRP and all logic.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  push one entry {wr_addr, wr_mask, wr_data}.
- wr_addr  in  7  DRP register address.
- wr_mask  in  16  1 = keep existing bit.
- wr_data  in  16  new bit values where mask = 0.
- start  in  1  apply buffered entries.
- count  out  $clog2(DEPTH)+1  entries buffered.
- full  out  1  count == DEPTH.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky timeout flag.
- drp_den, drp_dwe  out  1 each  DRP enable / write enable.
- drp_daddr  out  7; drp_di  out  16  DRP address / write data.
- drp_do  in  16; drp_drdy  in  1  DRP read data / ready.
- pll_rst  out  1  PLL reset.
- pll_locked  in  1  asynchronous PLL lock.

Function
REQ-005 SHALL synchronise pll_locked through two flops (locked_s) before any use.
REQ-006 SHALL accept wr_en only in IDLE with full = 0; otherwise the entry is dropped and count is unchanged.
REQ-007 SHALL, on wr_en and start in the same IDLE cycle, accept the entry and include it in the batch.
REQ-008 SHALL ignore start when count = 0 or busy = 1.
REQ-009 SHALL implement states IDLE, HOLD, RD, RD_WAIT, WR, WR_WAIT, RELEASE, LOCK_WAIT; busy = 1 in every state except IDLE.
REQ-010 SHALL, on start in IDLE, enter HOLD and assert pll_rst on the next cycle.
REQ-011 SHALL keep pll_rst high from HOLD until RELEASE.
REQ-012 SHALL stay in HOLD until locked_s = 0, then enter RD.
REQ-013 SHALL, in RD, pulse drp_den for exactly one cycle with drp_dwe = 0 and drp_daddr = head address, then enter RD_WAIT.
REQ-014 SHALL, in RD_WAIT, capture drp_do on drp_drdy = 1 and enter WR.
REQ-015 SHALL, in WR, pulse drp_den and drp_dwe together for exactly one cycle, with drp_di = (captured & mask) | (data & ~mask) and the same address, then enter WR_WAIT.
REQ-016 SHALL, in WR_WAIT on drp_drdy, pop the head entry (FIFO order), decrement count, then go to RD if entries remain, else to RELEASE.
REQ-017 SHALL hold drp_den and drp_dwe low outside their single pulse cycles, with at most one DRP transaction outstanding.
REQ-018 SHALL, in RELEASE, deassert pll_rst and enter LOCK_WAIT.
REQ-019 SHALL pulse done one cycle after locked_s is first seen high in LOCK_WAIT, and return to IDLE in that same cycle.
REQ-020 SHALL count cycles in RD_WAIT/WR_WAIT; on reaching DRDY_TIMEOUT it sets error, flushes the buffer (count = 0), deasserts pll_rst, pulses done and returns to IDLE.
REQ-021 SHALL count cycles in HOLD and LOCK_WAIT; on reaching LOCK_TIMEOUT it sets error, deasserts pll_rst, pulses done and returns to IDLE.
REQ-022 SHALL clear the timeout counter on every state change.
REQ-023 SHALL clear error only on an accepted start or on rst.
REQ-024 SHALL ignore drp_drdy outside RD_WAIT/WR_WAIT.

Reset
REQ-025 SHALL, on rst = 1 at a clk edge, enter IDLE and force count = 0, busy = 0, done = 0, error = 0, drp_den = 0, drp_dwe = 0, drp_daddr = 0, drp_di = 0, pll_rst = 0, and clear both sync flops.
REQ-026 SHALL, on rst mid-sequence, abort any DRP transaction without issuing further pulses and release pll_rst on the next cycle.

Verification
REQ-027 Single entry: write addr 0x08, mask 0x1000, data 0x0145; DRP model returns 0xFFFF; start -> one read of 0x08, then one write of 0x08 with di = 0x1145; pll_rst high throughout; lock after release -> one done pulse, error = 0.
REQ-028 Full buffer: 8 writes, then a 9th wr_en -> count = 8, full = 1, 9th entry dropped; start -> 8 read/write pairs in entry order.
REQ-029 DRDY timeout: drp_drdy held low after the first read -> error = 1 and done pulse at cycle 255, count = 0, pll_rst = 0.
REQ-030 Lock timeout: pll_locked held low after release -> error = 1 and done after 65535 cycles; a following start clears error.
REQ-031 Edge cases: start with count = 0 -> no DRP activity, busy stays 0; wr_en while busy -> dropped; wr_en + start in the same cycle -> entry applied.
REQ-032 rst asserted in WR_WAIT -> next cycle all outputs at reset values, count = 0, no further drp_den pulses.
